pe_operand_accumulator: RTL and testbench

Sequential stage directly downstream of the PE's 8-bit two-to-one operand mux. It drives the mux select line, consumes the selected 8-bit operand stream through a valid/ready handshake, and accumulates a programmable-length frame. The frame sum is presented through an output valid/ready handshake to the next PE stage.

---
 rtl/pe_pkg.sv | 14 +
 rtl/pe_operand_accumulator_if.sv | 34 +++
 rtl/pe_acc_adder.sv | 27 ++
 rtl/pe_operand_accumulator.sv | 86 ++++++++
 tb/tb_pe_operand_accumulator.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared constants and FSM state encoding for the PE operand accumulator slice.
package pe_pkg;

  localparam int unsigned PE_DATA_W = 8;
  localparam int unsigned PE_ACC_W  = 10;
  localparam int unsigned PE_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pe_state_e;

endpackage

// File: rtl/pe_operand_accumulator_if.sv
// Operand-in / sum-out handshake bundle between the operand mux, the accumulator and the next stage.
interface pe_operand_accumulator_if
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ACC_W  = PE_ACC_W,
  parameter int unsigned CNT_W  = PE_CNT_W
) ();

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              busy;
  logic              mux_s;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;
  logic              out_valid;
  logic              out_ready;

  // Accumulator side.
  modport slave (
    input  start, len, in_data, in_valid, out_ready,
    output busy, mux_s, in_ready, out_sum, out_ovf, out_valid
  );

  // Environment side: frame control, operand source and result sink.
  modport master (
    output start, len, in_data, in_valid, out_ready,
    input  busy, mux_s, in_ready, out_sum, out_ovf, out_valid
  );

endinterface

// File: rtl/pe_acc_adder.sv
// Combinational accumulator adder with carry out. With PE_ACC_SATURATE_EN defined the result
// clamps to all-ones on carry; otherwise it wraps modulo 2^ACC_W.
module pe_acc_adder
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ACC_W  = PE_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DATA_W-1:0] operand,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] wide;

  always_comb begin
    wide  = {1'b0, acc} + {{(ACC_W + 1 - DATA_W){1'b0}}, operand};
    carry = wide[ACC_W];
`ifdef PE_ACC_SATURATE_EN
    sum   = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    sum   = wide[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/pe_operand_accumulator.sv
// Frame accumulator behind the PE operand mux: drives mux select, sums a programmable-length frame
// and hands the result downstream. Overflow policy follows PE_ACC_SATURATE_EN (see pe_acc_adder).
module pe_operand_accumulator
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = PE_DATA_W,
  parameter int unsigned ACC_W  = PE_ACC_W,
  parameter int unsigned CNT_W  = PE_CNT_W
) (
  input logic                     clk,
  input logic                     reset,
  pe_operand_accumulator_if.slave bus
);

  pe_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mux_q;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;
  logic             start_ok;

  assign accept   = (state_q == ACCUM) && bus.in_valid;
  assign start_ok = (state_q == IDLE) && bus.start;

  pe_acc_adder #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_adder (
    .acc     (acc_q),
    .operand (bus.in_data),
    .sum     (add_sum),
    .carry   (add_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = ACCUM;
      ACCUM:   if (accept && (cnt_q == '0)) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ACCUM);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.out_sum   = acc_q;
    bus.out_ovf   = ovf_q;
    bus.mux_s     = mux_q;
  end

  // cnt counts down remaining samples; the frame ends on the accept that sees it at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
      mux_q <= 1'b0;
    end else if (start_ok) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= bus.len;
      mux_q <= 1'b0;
    end else if (accept) begin
      acc_q <= add_sum;
      ovf_q <= ovf_q | add_carry;
      mux_q <= ~mux_q;
      if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_operand_accumulator.sv
// Self-checking bench for pe_operand_accumulator: frame-level model plus directed literal checks.
module tb_pe_operand_accumulator;
  import pe_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pe_operand_accumulator_if bus ();

  pe_operand_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 collecting samples, 2 result pending.
  int m_phase = 0;
  int m_left  = 0;
  int m_total = 0;
  bit m_mux   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_left  = 0;
      m_total = 0;
      m_mux   = 1'b0;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
          m_phase = 1;
          m_left  = int'(bus.len) + 1;
          m_total = 0;
          m_mux   = 1'b0;
        end
        1: if (bus.in_valid) begin
          m_total += int'(bus.in_data);
          m_mux   = !m_mux;
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (bus.out_ready) m_phase = 0;
      endcase
    end
  end

  function automatic int exp_sum(input int total);
`ifdef PE_ACC_SATURATE_EN
    return (total > 1023) ? 1023 : total;
`else
    return total % 1024;
`endif
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      check("model_in_ready", bus.in_ready, m_phase == 1);
      check("model_out_valid", bus.out_valid, m_phase == 2);
      check("model_busy", bus.busy, m_phase != 0);
      check("model_mux_s", bus.mux_s, m_mux);
      if (m_phase == 2) begin
        check("model_out_sum", bus.out_sum, exp_sum(m_total));
        check("model_out_ovf", bus.out_ovf, m_total > 1023);
      end
    end
  end

  int samples[16];
  logic [9:0] got_sum;
  logic got_ovf;
  logic got_mux;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Runs one frame of n samples with gap idle cycles between samples, then optionally stalls
  // the result for stall_out cycles (pulsing start meanwhile) before completing the handshake.
  task automatic run_frame(input int n, input int gap, input int stall_out);
    int w;
    bus.start = 1'b1;
    bus.len   = 4'(n - 1);
    cyc();
    bus.start = 1'b0;
    check("in_ready_after_start", bus.in_ready, 1);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(samples[i]);
      check("mux_at_accept", bus.mux_s, i % 2);
      cyc();
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      if (i < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          cyc();
          check("mux_hold_stall", bus.mux_s, (i + 1) % 2);
        end
      end
    end
    w = 0;
    while (!bus.out_valid && w < 5) begin
      cyc();
      w++;
    end
    check("out_valid_latency", w, 0);
    got_sum = bus.out_sum;
    got_ovf = bus.out_ovf;
    got_mux = bus.mux_s;
    for (int k = 0; k < stall_out; k++) begin
      bus.start = (k == 2);
      bus.len   = 4'd0;
      cyc();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_sum", bus.out_sum, got_sum);
      check("bp_in_ready", bus.in_ready, 0);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    check("busy_after_handshake", bus.busy, 0);
    check("out_valid_after_handshake", bus.out_valid, 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("rst_mux_s", bus.mux_s, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_sum", bus.out_sum, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    check("idle_busy", bus.busy, 0);

    // Continuous frame.
    samples[0] = 10; samples[1] = 20; samples[2] = 30; samples[3] = 40;
    run_frame(4, 0, 0);
    check("cont_sum", got_sum, 100);
    check("cont_ovf", got_ovf, 0);
    check("cont_mux_end", got_mux, 0);

    // Stalled input.
    run_frame(4, 3, 0);
    check("stall_sum", got_sum, 100);
    check("stall_ovf", got_ovf, 0);

    // Overflow.
    for (int i = 0; i < 16; i++) samples[i] = 255;
    run_frame(16, 0, 0);
`ifdef PE_ACC_SATURATE_EN
    check("ovf_sum", got_sum, 1023);
`else
    check("ovf_sum", got_sum, 1008);
`endif
    check("ovf_flag", got_ovf, 1);

    // Output backpressure with an ignored start pulse.
    samples[0] = 1; samples[1] = 2;
    run_frame(2, 0, 5);
    check("bp_sum", got_sum, 3);

    // Reset mid-frame after two accepts.
    samples[0] = 50; samples[1] = 60;
    bus.start = 1'b1;
    bus.len   = 4'd3;
    cyc();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd50;
    cyc();
    bus.in_data  = 8'd60;
    cyc();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_mux_s", bus.mux_s, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_sum", bus.out_sum, 0);
    check("midrst_out_ovf", bus.out_ovf, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    cyc();
    reset = 1'b0;
    cyc();
    samples[0] = 7;
    run_frame(1, 0, 0);
    check("post_rst_sum", got_sum, 7);
    check("post_rst_ovf", got_ovf, 0);
    check("post_rst_mux", got_mux, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
